// File: rtl/siso_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// siso_tx_pkg
// Shared types and helpers for the siso_tx_arbiter slice.
//   tx_state_e : sequencer states (PARITY is only reachable when the
//                SISO_TX_ARBITER_PARITY_EN build option is defined)
//   calc_idw   : width of a requester ID field for a given requester count
// -----------------------------------------------------------------------------
package siso_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } tx_state_e;

  // ID width for n requesters; never narrower than one bit.
  function automatic int calc_idw(input int n);
    int w;
    if (n <= 2) begin
      w = 1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

endpackage

// File: rtl/siso_tx_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. Searches upward from ptr_i+1 with
// wrap-around and grants the first asserted request.
//   req_i : request vector
//   ptr_i : ID of the most recent winner (search starts just above it)
//   en_i  : when low no grant is issued
//   gnt_o : one-hot grant (all zero when disabled or nothing requested)
//   id_o  : encoded ID of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
  import siso_tx_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = calc_idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     id_o
);

  int   idx_s;
  logic found_s;

  // Rotating first-one search starting one position above the pointer.
  always_comb begin
    gnt_o   = '0;
    id_o    = '0;
    idx_s   = 0;
    found_s = 1'b0;
    if (en_i) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx_s = (int'(ptr_i) + k) % NUM_REQ;
        if (!found_s && req_i[idx_s]) begin
          found_s      = 1'b1;
          gnt_o[idx_s] = 1'b1;
          id_o         = IDW'(idx_s);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      gnt_o = '0;
    end
  end

endmodule

// File: rtl/siso_tx_arbiter.sv
// -----------------------------------------------------------------------------
// siso_tx_arbiter
// Shares one serial shift-out channel among NUM_REQ parallel requesters.
// A requester is chosen round-robin, its WIDTH-bit word captured, and the word
// shifted out MSB-first one bit per enabled cycle, followed by a one-cycle
// done pulse carrying the served requester's ID.
//
// Build option: SISO_TX_ARBITER_PARITY_EN -- when defined, one even-parity bit
// of the captured word is appended after the data bits (frame = WIDTH+1 bits).
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   enable      shift-advance qualifier (low pauses shifting and arbitration)
//   req_valid   per-requester word valid
//   req_data    packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready   one-hot accept, only ever asserted in IDLE
//   ser_out     serial data bit
//   ser_valid   ser_out carries a frame bit this cycle
//   frame_start high with the first (MSB) bit of a frame
//   done        one-cycle pulse after the last frame bit
//   done_id     requester served, valid while done=1
//   grant_id    requester owning the current/last frame
//   busy        state is not IDLE
// -----------------------------------------------------------------------------
module siso_tx_arbiter
  import siso_tx_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IDW     = calc_idw(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     ser_out,
  output logic                     ser_valid,
  output logic                     frame_start,
  output logic                     done,
  output logic [IDW-1:0]           done_id,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  tx_state_e          state_q;
  logic [WIDTH-1:0]   shift_q;
  logic [CW-1:0]      cnt_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     grant_q;

  logic               arb_en_s;
  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [IDW-1:0]     arb_id_s;
  logic               handshake_s;
  logic [WIDTH-1:0]   sel_word_s;

`ifdef SISO_TX_ARBITER_PARITY_EN
  logic               parity_q;

  // Even parity: XOR of all bits, so the frame carries an even count of ones.
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`endif

  // Arbitration only in IDLE with enable high; reset also forces ready low
  // so every output reads 0 while reset is held.
  assign arb_en_s = enable && (state_q == IDLE) && !reset;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (arb_en_s),
    .gnt_o (arb_gnt_s),
    .id_o  (arb_id_s)
  );

  assign req_ready   = arb_gnt_s;
  assign handshake_s = |(req_valid & arb_gnt_s);

  // Select the winner's word from the packed request bus.
  always_comb begin
    sel_word_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_id_s == IDW'(i)) begin
        sel_word_s = req_data[i*WIDTH +: WIDTH];
      end else begin
        sel_word_s = sel_word_s;
      end
    end
  end

  // Sequencer: capture on handshake, shift on enable, pulse done, return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= IDW'(NUM_REQ - 1);
      grant_q  <= '0;
`ifdef SISO_TX_ARBITER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake_s) begin
            shift_q  <= sel_word_s;
            grant_q  <= arb_id_s;
            ptr_q    <= arb_id_s;
            cnt_q    <= '0;
`ifdef SISO_TX_ARBITER_PARITY_EN
            parity_q <= even_parity(sel_word_s);
`endif
            state_q  <= SHIFT;
          end else begin
            state_q  <= IDLE;
          end
        end
        SHIFT: begin
          if (enable) begin
            // Zero fill leaves the register clear once the frame is out,
            // so ser_out idles low.
            shift_q <= {shift_q[WIDTH-2:0], 1'b0};
            if (cnt_q == LAST_BIT) begin
              cnt_q   <= '0;
`ifdef SISO_TX_ARBITER_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= DONE;
`endif
            end else begin
              cnt_q   <= cnt_q + CW'(1'b1);
            end
          end else begin
            state_q <= SHIFT;
          end
        end
`ifdef SISO_TX_ARBITER_PARITY_EN
        PARITY: begin
          if (enable) begin
            state_q <= DONE;
          end else begin
            state_q <= PARITY;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output decode from the state registers; enable only qualifies validity.
  always_comb begin
    ser_out     = shift_q[WIDTH-1];
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    done_id     = '0;
    case (state_q)
      SHIFT: begin
        ser_valid   = enable;
        frame_start = enable && (cnt_q == '0);
      end
`ifdef SISO_TX_ARBITER_PARITY_EN
      PARITY: begin
        ser_out   = parity_q;
        ser_valid = enable;
      end
`endif
      DONE: begin
        done    = 1'b1;
        done_id = grant_q;
      end
      default: begin
        ser_valid = 1'b0;
      end
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_siso_tx_arbiter.sv
module tb_siso_tx_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            ser_out;
  logic            ser_valid;
  logic            frame_start;
  logic            done;
  logic [1:0]      done_id;
  logic [1:0]      grant_id;
  logic            busy;

  siso_tx_arbiter #(.NUM_REQ(NREQ), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .done        (done),
    .done_id     (done_id),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Expected output events: a serial bit (with its frame_start flag) or a
  // done pulse (val holds the expected ID).
  typedef struct {
    logic       is_done;
    logic [7:0] val;
    logic       fs;
  } ev_t;

  ev_t        expq[$];
  logic [7:0] wq[NREQ][$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  int         rdy_cnt[NREQ];
  int         gap_by_id[NREQ];
  int         last_done_cyc = -100;
  logic [NREQ-1:0] hs_s;
  ev_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Producer model: each requester presents the head of its word queue.
  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (wq[i].size() > 0) begin
        req_valid[i]     = 1'b1;
        req_data[i*W +: W] = wq[i][0];
      end else begin
        req_valid[i]     = 1'b0;
        req_data[i*W +: W] = 8'h00;
      end
    end
  endtask

  task automatic load(input int id, input logic [7:0] d);
    wq[id].push_back(d);
    drive_reqs();
  endtask

  task automatic cycle();
    @(negedge clk);
    hs_s = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs_s[i] && wq[i].size() > 0) wq[i].delete(0);
    drive_reqs();
  endtask

  task automatic push_bits(input logic [7:0] d, input int n);
    ev_t e;
    for (int b = 0; b < n; b++) begin
      e.is_done = 1'b0;
      e.val     = {7'd0, d[7-b]};
      e.fs      = (b == 0);
      expq.push_back(e);
    end
  endtask

  task automatic push_frame(input int id, input logic [7:0] d, input logic par);
    ev_t e;
    push_bits(d, 8);
`ifdef SISO_TX_ARBITER_PARITY_EN
    e.is_done = 1'b0;
    e.val     = {7'd0, par};
    e.fs      = 1'b0;
    expq.push_back(e);
`endif
    e.is_done = 1'b1;
    e.val     = 8'(id);
    e.fs      = 1'b0;
    expq.push_back(e);
  endtask

  task automatic wait_hs(input int id);
    int n;
    n = 0;
    cycle();
    while (!hs_s[id] && n < 100) begin
      cycle();
      n++;
    end
    check($sformatf("handshake_req%0d", id), {31'd0, hs_s[id]}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 300) begin
      cycle();
      n++;
    end
    check("drain_expected_queue", expq.size(), 32'd0);
  endtask

  // Monitor: compare every presented bit / done pulse against the scoreboard.
  always @(negedge clk) begin
    if (ser_valid) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL ser_bit: unexpected bit %b at cycle %0d, required none", ser_out, cyc);
      end else begin
        mon_e = expq.pop_front();
        if (mon_e.is_done || ser_out !== mon_e.val[0] || frame_start !== mon_e.fs) begin
          miscompares++;
          $display("FAIL ser_bit cycle %0d: got bit=%b fs=%b, required %s bit=%b fs=%b",
                   cyc, ser_out, frame_start, mon_e.is_done ? "done" : "data",
                   mon_e.val[0], mon_e.fs);
        end
      end
    end else if (frame_start) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_start: got 1 without ser_valid at cycle %0d, required 0", cyc);
    end
    if (frame_start) gap_by_id[grant_id] = cyc - last_done_cyc;
    if (done) begin
      vectors++;
      last_done_cyc = cyc;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL done: unexpected done id=%0d at cycle %0d, required none", done_id, cyc);
      end else begin
        mon_e = expq.pop_front();
        if (!mon_e.is_done || done_id !== mon_e.val[1:0]) begin
          miscompares++;
          $display("FAIL done cycle %0d: got done id=%0d, required %s id=%0d",
                   cyc, done_id, mon_e.is_done ? "done" : "data bit", mon_e.val[1:0]);
        end
      end
    end
    if (req_ready != '0) begin
      vectors++;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (busy || $countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
        miscompares++;
        $display("FAIL req_ready: got %b (busy=%b valid=%b), required one-hot valid in idle",
                 req_ready, busy, req_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rdy_cnt[i]   = 0;
      gap_by_id[i] = 0;
    end
    #1;
    check("reset_outputs",
          {18'd0, req_ready, ser_out, ser_valid, frame_start, done, done_id, grant_id, busy}, 32'd0);
    cycle();
    cycle();
    reset  = 1'b0;
    enable = 1'b1;

    // Abort mid-frame: only the first four bits of 8'hC3 appear, no done.
    load(1, 8'hC3);
    push_bits(8'hC3, 4);
    wait_hs(1);
    repeat (4) cycle();
    reset = 1'b1;
    load(0, 8'h3C);
    load(2, 8'h81);
    #1;
    check("reset_abort_outputs",
          {18'd0, req_ready, ser_out, ser_valid, frame_start, done, done_id, grant_id, busy}, 32'd0);
    check("abort_bits_consumed", expq.size(), 32'd0);
    cycle();
    reset = 1'b0;

    // After reset requester 0 has priority over 2.
    push_frame(0, 8'h3C, 1'b0);
    push_frame(2, 8'h81, 1'b0);
    drain();

    // Single frame 8'hA5 from requester 1.
    load(1, 8'hA5);
    push_frame(1, 8'hA5, 1'b0);
    drain();

    // Hold-off: requester 3 arrives mid-frame, waits, starts 2 cycles after done.
    load(0, 8'h96);
    push_frame(0, 8'h96, 1'b0);
    wait_hs(0);
    repeat (2) cycle();
    load(3, 8'h5A);
    push_frame(3, 8'h5A, 1'b0);
    check("req3_not_ready_while_busy", {31'd0, req_ready[3]}, 32'd0);
    drain();
    check("gap_done_to_req3_msb", gap_by_id[3], 32'd2);

    // Fairness: all four held valid, pointer last on 3 -> 0,1,2,3,0,1.
    for (int i = 0; i < NREQ; i++) rdy_cnt[i] = 0;
    load(0, 8'h11); load(0, 8'h55);
    load(1, 8'h22); load(1, 8'h66);
    load(2, 8'h33);
    load(3, 8'h44);
    push_frame(0, 8'h11, 1'b0);
    push_frame(1, 8'h22, 1'b0);
    push_frame(2, 8'h33, 1'b0);
    push_frame(3, 8'h44, 1'b0);
    push_frame(0, 8'h55, 1'b0);
    push_frame(1, 8'h66, 1'b0);
    drain();
    check("ready_cycles_req0", rdy_cnt[0], 32'd2);
    check("ready_cycles_req1", rdy_cnt[1], 32'd2);
    check("ready_cycles_req2", rdy_cnt[2], 32'd1);
    check("ready_cycles_req3", rdy_cnt[3], 32'd1);
    check("gap_back_to_back", gap_by_id[1], 32'd2);

    // Pause after bit 3 of 8'hF0 for three cycles.
    load(2, 8'hF0);
    push_frame(2, 8'hF0, 1'b0);
    wait_hs(2);
    repeat (4) cycle();
    for (int p = 0; p < 3; p++) begin
      enable = 1'b0;
      #1;
      check($sformatf("pause_ser_valid_%0d", p), {31'd0, ser_valid}, 32'd0);
      check($sformatf("pause_ser_out_%0d", p), {31'd0, ser_out}, 32'd0);
      cycle();
    end
    enable = 1'b1;
    drain();

    // Parity-sensitive words (odd and even count of ones).
    load(1, 8'h07);
    push_frame(1, 8'h07, 1'b1);
    drain();
    load(3, 8'hA5);
    push_frame(3, 8'hA5, 1'b0);
    drain();

    repeat (3) cycle();
    check("final_queue_empty", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/siso_tx_arbiter.md
Name: siso_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one serial shift-out channel among NUM_REQ requesters.
- Each requester offers a WIDTH-bit parallel word with a valid/ready handshake.
- The block grants one requester, captures its word, and shifts it out MSB-first, one bit per enabled cycle.
- It reports completion with a done pulse and the ID of the requester served. It sits between parallel producers and a single-bit serial link.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 8, bits per serial frame (>=2).
- IDW, $clog2(NUM_REQ), width of requester ID fields (derived localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  shift-advance qualifier; low pauses the shifter.
- req_valid  input  NUM_REQ  per-requester word-valid.
- req_data  input  NUM_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot accept; transfer occurs when req_valid[i]&req_ready[i].
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  high with the first (MSB) bit of a frame.
- done  output  1  one-cycle pulse after the last bit of a frame.
- done_id  output  IDW  requester served; valid while done=1.
- grant_id  output  IDW  requester owning the current frame; holds its last value in IDLE.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; shift register and bit counter clear.
  - The round-robin pointer is set to NUM_REQ-1, so requester 0 has first priority.
  - All outputs are 0; any frame in progress is aborted with no done pulse.
- States: IDLE, SHIFT, DONE (plus PARITY when the optional feature is enabled).
- IDLE:
  - req_ready is combinational. It is one-hot on the first requester with req_valid=1, searching upward from pointer+1 with wrap-around. It is zero when enable=0 or no request is valid.
  - On the handshake, the word is captured, grant_id and pointer are set to the winner, and the state moves to SHIFT.
- Latency: the handshake in cycle N gives the MSB on ser_out in cycle N+1.
- SHIFT:
  - ser_out = shift_reg[WIDTH-1]; ser_valid = enable.
  - On each enable=1 cycle the register shifts left, filling with 0, and the counter increments.
  - enable=0 freezes the register, counter and ser_out; ser_valid=0.
  - frame_start=1 only while the counter is 0 and enable=1.
  - After the bit with counter=WIDTH-1 is sent: move to DONE (or PARITY) and clear the counter.
- DONE:
  - done=1 and done_id=grant_id for exactly one cycle, regardless of enable.
  - Then go to IDLE. The next arbitration can happen in the following cycle, so back-to-back frames are separated by 2 non-data cycles.
- req_ready is 0 in every state except IDLE. New or held requests simply wait; no request is dropped.
- The counter is $clog2(WIDTH) bits with an explicit compare against WIDTH-1, so it never wraps silently.
- A requester deasserting req_valid without a handshake is legal and is not granted.

Optional Feature:
- Macro: SISO_TX_ARBITER_PARITY_EN.
- Defined:
  - After the last data bit, the PARITY state sends one extra bit: the even parity (XOR) of the captured word.
  - It uses ser_valid=1 and is paused by enable like a data bit.
  - Then the state moves to DONE. A frame is WIDTH+1 bits.
- Undefined: there is no PARITY state; frames are WIDTH bits.

Decomposition:
- Package siso_tx_pkg holds:
  - the state enum typedef (tx_state_e: IDLE, SHIFT, PARITY, DONE);
  - a function computing IDW from NUM_REQ.
- One sub-module, rr_arbiter:
  - parameterised NUM_REQ;
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and encoded ID;
  - purely combinational.
- Shifter, counter and FSM stay in the top module.

Test Plan:
- Reset values: assert reset mid-frame at bit 4 → all outputs 0 immediately, no done. After release, req0 and req2 valid → req0 granted first.
- Single frame: req1 valid, data 8'hA5, enable=1 → ser_out 1,0,1,0,0,1,0,1 over 8 cycles, frame_start on the first bit, then done=1 with done_id=1 for one cycle.
- Simultaneous and fair: all 4 requesters held valid continuously → grant order 0,1,2,3,0,1, and each req_ready is high for exactly one cycle per grant.
- Pause: enable=0 for 3 cycles after bit 3 of 8'hF0 → ser_valid=0 and ser_out held for those cycles. The frame still delivers exactly 8 bits 1,1,1,1,0,0,0,0.
- Busy/hold-off: req3 asserts during req0's frame → req_ready[3]=0 until IDLE. req3 is then granted, with its MSB two cycles after req0's done.
- Parity (macro defined): data 8'h07 → 9th bit is 1; data 8'hA5 → 9th bit is 0; done follows the 9th bit.
